// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: time-slices one segment bus across
// NUM_DIGITS active-low anodes, with ghosting guard, blanking, blinking and frame-synchronous word updates.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 7,
  parameter int CLK_DIV      = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] word_in,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       blank_mask,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic                        blink_en,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       anode,
  output logic                        pending
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]               r_presc;
  logic [IW-1:0]               r_idx;
  logic [FW-1:0]               r_frame_cnt;
  logic                        r_blink_phase;
  logic [NUM_DIGITS*SEG_W-1:0] r_active;
  logic [NUM_DIGITS*SEG_W-1:0] r_pend_word;
  logic                        r_pending;
  logic [SEG_W-1:0]            r_seg_out;
  logic [NUM_DIGITS-1:0]       r_anode;

  logic                        w_tick;
  logic                        w_frame;
  logic                        w_dark;
  logic [NUM_DIGITS-1:0]       w_anode_next;
  logic [SEG_W-1:0]            w_digits [NUM_DIGITS];

  assign w_tick  = (r_presc == PRESC_MAX);
  assign w_frame = w_tick && (r_idx == IDX_MAX);

  // Digit 0 occupies the most significant SEG_W bits of the word.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_digits[gi] = r_active[(NUM_DIGITS-gi)*SEG_W-1 -: SEG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      if (w_frame) begin
        if (r_frame_cnt == FRAME_MAX) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // Words only reach the display at a frame boundary; a load landing exactly
  // on the boundary bypasses the pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= '1;
      r_pend_word <= '1;
      r_pending   <= 1'b0;
    end else if (w_frame) begin
      if (load) begin
        r_active  <= word_in;
        r_pending <= 1'b0;
      end else if (r_pending) begin
        r_active  <= r_pend_word;
        r_pending <= 1'b0;
      end
    end else if (load) begin
      r_pend_word <= word_in;
      r_pending   <= 1'b1;
    end
  end

  assign w_dark = blank_mask[r_idx] | (blink_en & blink_mask[r_idx] & r_blink_phase);

  always_comb begin
    w_anode_next = '1;
    if ((r_presc >= GUARD_END) && !w_dark) begin
      w_anode_next[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_out <= '1;
      r_anode   <= '1;
    end else begin
      r_seg_out <= w_digits[r_idx];
      r_anode   <= w_anode_next;
    end
  end

  assign seg_out = r_seg_out;
  assign anode   = r_anode;
  assign pending = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a fast scan (CLK_DIV=4, GUARD=1,
// BLINK_FRAMES=2); expected anode patterns are written out per slot position.
module tb_seg_scan_driver;
  localparam int ND = 4;
  localparam int SW = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic [ND*SW-1:0]   word_in;
  logic               load;
  logic [ND-1:0]      blank_mask;
  logic [ND-1:0]      blink_mask;
  logic               blink_en;
  logic [SW-1:0]      seg_out;
  logic [ND-1:0]      anode;
  logic               pending;

  int n_cmp = 0;
  int n_err = 0;

  // Anode pattern for each of the 16 clocks of a frame, masks clear.
  logic [3:0] scan_tab [16] = '{4'hF, 4'hE, 4'hE, 4'hE,
                                4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB,
                                4'hF, 4'h7, 4'h7, 4'h7};
  // Digits 0..3 of the word loaded at the frame boundary.
  logic [6:0] word2_dig [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
  logic [3:0] exp_an;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SEG_W(SW), .CLK_DIV(4), .GUARD(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .load(load),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .blink_en(blink_en),
    .seg_out(seg_out), .anode(anode), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; word_in = '0;
    blank_mask = '0; blink_mask = '0; blink_en = 1'b0;
    step(); step();
    chk("reset_anode", 32'(anode), 32'hF);
    chk("reset_seg", 32'(seg_out), 32'h7F);
    chk("reset_pending", 32'(pending), 32'h0);
    rst = 1'b0;

    // Two full frames of scanning after reset.
    for (int e = 0; e < 32; e++) begin
      step();
      chk($sformatf("scan_anode_%0d", e), 32'(anode), 32'(scan_tab[e % 16]));
      chk($sformatf("scan_seg_%0d", e), 32'(seg_out), 32'h7F);
    end
    $display("scan: 32 clocks checked");

    // Mid-frame load is held until the frame boundary.
    word_in = 28'h0000001; load = 1'b1;
    step();
    load = 1'b0;
    chk("midload_pending", 32'(pending), 32'h1);
    chk("midload_seg", 32'(seg_out), 32'h7F);
    for (int e = 1; e < 15; e++) begin
      step();
      chk($sformatf("hold_pending_%0d", e), 32'(pending), 32'h1);
      chk($sformatf("hold_seg_%0d", e), 32'(seg_out), 32'h7F);
    end
    step();
    chk("boundary_pending", 32'(pending), 32'h0);
    chk("boundary_seg_old", 32'(seg_out), 32'h7F);
    for (int e = 0; e < 16; e++) begin
      step();
      chk($sformatf("newword_seg_%0d", e), 32'(seg_out), ((e / 4) == 3) ? 32'h01 : 32'h00);
      chk($sformatf("newword_anode_%0d", e), 32'(anode), 32'(scan_tab[e]));
    end
    $display("midframe load: word 0000001 displayed after boundary");

    // Load exactly on the frame boundary tick bypasses pending.
    for (int e = 0; e < 15; e++) step();
    word_in = {7'h3F, 7'h06, 7'h5B, 7'h4F}; load = 1'b1;
    step();
    load = 1'b0;
    chk("bndload_pending", 32'(pending), 32'h0);
    chk("bndload_seg_old", 32'(seg_out), 32'h01);
    for (int e = 0; e < 16; e++) begin
      step();
      chk($sformatf("bndload_seg_%0d", e), 32'(seg_out), 32'(word2_dig[e / 4]));
      chk($sformatf("bndload_pend_%0d", e), 32'(pending), 32'h0);
    end
    $display("boundary load: new word shown next frame");

    // Blanking digit 2.
    blank_mask = 4'b0100;
    for (int e = 0; e < 16; e++) begin
      step();
      exp_an = ((e / 4) == 2) ? 4'hF : scan_tab[e];
      chk($sformatf("blank_anode_%0d", e), 32'(anode), 32'(exp_an));
      chk($sformatf("blank_seg_%0d", e), 32'(seg_out), 32'(word2_dig[e / 4]));
    end
    blank_mask = '0;
    $display("blanking: digit 2 kept dark");

    // Reset with a word pending; a load during reset is ignored.
    for (int e = 0; e < 5; e++) step();
    word_in = 28'h1234567; load = 1'b1;
    step();
    chk("prerst_pending", 32'(pending), 32'h1);
    rst = 1'b1;
    step();
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_seg", 32'(seg_out), 32'h7F);
    rst = 1'b0; load = 1'b0;
    $display("mid-frame reset: pending discarded");

    // Blink digit 0: lit for frames 0-1, dark 2-3, lit again in frame 4.
    blink_en = 1'b1; blink_mask = 4'b0001;
    for (int e = 0; e < 80; e++) begin
      step();
      exp_an = scan_tab[e % 16];
      if (((e / 16) == 2 || (e / 16) == 3) && ((e % 16) / 4) == 0) exp_an = 4'hF;
      chk($sformatf("blink_anode_%0d", e), 32'(anode), 32'(exp_an));
      chk($sformatf("blink_seg_%0d", e), 32'(seg_out), 32'h7F);
    end
    $display("blink: 5 frames checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
